wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-003 SHALL have ports: wb_stall  in  1  register-file write port unavailable this cycle.
REQ-004 SHALL have ports: alu_wb_req / shf_wb_req / mem_wb_req  in  1 each  unit holds a result for writeback.
REQ-005 SHALL have ports: alu_wb_addr / shf_wb_addr / mem_wb_addr  in  5 each  destination register.
REQ-006 SHALL have ports: alu_wb_data / shf_wb_data / mem_wb_data  in  32 each  result value.
REQ-007 SHALL have ports: alu_wb_grant / shf_wb_grant / mem_wb_grant  out  1 each  combinational accept; unit drops or replaces request next cycle.
REQ-008 SHALL have ports: wb_reg_writereg  out  1  register-file write enable, registered.
REQ-009 SHALL have ports: wb_reg_addr  out  5  registered write address.
REQ-010 SHALL have ports: wb_reg_data  out  32  registered write data.
REQ-011 SHALL have ports: wb_sb_clear  out  1  registered pulse telling scoreboard that wb_reg_addr is no longer pending.

Function
REQ-012 SHALL assert at most one grant per cycle (one-hot or zero).
REQ-013 SHALL assert no grant while wb_stall=1 or reset=1.
REQ-014 SHALL grant only a requester whose req=1 in the same cycle; grant with req=0 is forbidden.
REQ-015 SHALL, one cycle after a grant, drive wb_reg_writereg=1, wb_reg_addr/wb_reg_data = granted unit's addr/data sampled at grant edge (latency 1).
REQ-016 SHALL drive wb_reg_writereg=0 in any cycle following a no-grant cycle; addr/data hold last value.
REQ-017 SHALL, when granted addr=0, drive wb_reg_writereg=0 but still pulse wb_sb_clear=1 (write to $zero discarded, requester retired).
REQ-018 SHALL pulse wb_sb_clear=1 for exactly one cycle per grant, aligned with REQ-015.
REQ-019 SHALL, with round-robin enabled, keep a 2-bit pointer last_grant in {ALU=0, SHF=1, MEM=2}; search order starts at last_grant+1 mod 3; pointer updates only on a grant.
REQ-020 SHALL leave pointer unchanged during wb_stall or idle cycles.
REQ-021 SHALL treat pointer value 3 (illegal) as 2 (next search starts at ALU).
REQ-022 SHALL, when all three request simultaneously and continuously, grant each exactly once in every 3 consecutive unstalled cycles.

Reset
REQ-023 SHALL on reset: all grants 0 combinationally, wb_reg_writereg=0, wb_reg_addr=0, wb_reg_data=0, wb_sb_clear=0, last_grant=2.
REQ-024 SHALL, if reset asserts in the cycle after a grant, suppress the pending write (outputs reset values next edge); requester is considered accepted.

Configuration
REQ-025 SHALL implement round-robin (REQ-019..022) when macro WB_ARB_ROUND_ROBIN_EN is defined.
REQ-026 SHALL, without WB_ARB_ROUND_ROBIN_EN, use fixed priority MEM > ALU > SHF, no pointer register; REQ-022 not applicable.

Structure
REQ-027 SHALL take unit index encodings (ALU=0, SHF=1, MEM=2) and width constants (REG_ADDR_W=5, DATA_W=32) from the shared pipeline package.
REQ-028 SHALL place the grant-selection logic in one sub-module rr_pick3 (req[2:0], ptr[1:0] -> grant one-hot); fixed-priority build bypasses it.

Verification
REQ-029 SHALL cover: ALU req addr=5 data=0xDEADBEEF alone -> alu_wb_grant same cycle; next cycle writereg=1, addr=5, data=0xDEADBEEF, sb_clear=1.
REQ-030 SHALL cover: all three req held 6 cycles after reset (RR build) -> grant order ALU, SHF, MEM, ALU, SHF, MEM.
REQ-031 SHALL cover: same stimulus, fixed-priority build -> MEM granted all 6 cycles, ALU/SHF none.
REQ-032 SHALL cover: MEM req addr=0 -> mem_wb_grant=1; next cycle writereg=0, sb_clear=1.
REQ-033 SHALL cover: wb_stall=1 for 3 cycles with ALU+SHF requesting -> no grants, writereg=0, pointer unchanged; first unstalled cycle grants per pointer.
REQ-034 SHALL cover: grant in cycle N, reset=1 in cycle N+1 -> at edge N+1 outputs writereg=0, sb_clear=0, addr=0, data=0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_pkg
// Brief    : Shared pipeline constants, unit indices and helpers for writeback.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_UNITS  = 3;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_SHF = 2'd1,
        UNIT_MEM = 2'd2
    } unit_e;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_UNITS-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[UNIT_SHF]) idx = UNIT_SHF;
        if (oh[UNIT_MEM]) idx = UNIT_MEM;
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick3.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick3
// Brief    : Three-way round-robin pick; search starts just after ptr
//            (ptr 2 and the illegal value 3 both restart the search at 0).
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant
);

    logic [1:0] start;

    always_comb begin
        grant = 3'b000;
        start = (ptr >= 2'd2) ? 2'd0 : ptr + 2'd1;
        case (start)
            2'd0: begin
                if      (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
            2'd1: begin
                if      (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            default: begin
                if      (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Writeback arbiter for ALU/SHF/MEM onto the register-file write
//            port. Define WB_ARB_ROUND_ROBIN_EN for round-robin; otherwise
//            fixed priority MEM > ALU > SHF.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_stall,
    input  logic                  alu_wb_req,
    input  logic                  shf_wb_req,
    input  logic                  mem_wb_req,
    input  logic [REG_ADDR_W-1:0] alu_wb_addr,
    input  logic [REG_ADDR_W-1:0] shf_wb_addr,
    input  logic [REG_ADDR_W-1:0] mem_wb_addr,
    input  logic [DATA_W-1:0]     alu_wb_data,
    input  logic [DATA_W-1:0]     shf_wb_data,
    input  logic [DATA_W-1:0]     mem_wb_data,
    output logic                  alu_wb_grant,
    output logic                  shf_wb_grant,
    output logic                  mem_wb_grant,
    output logic                  wb_reg_writereg,
    output logic [REG_ADDR_W-1:0] wb_reg_addr,
    output logic [DATA_W-1:0]     wb_reg_data,
    output logic                  wb_sb_clear
);

    logic [NUM_UNITS-1:0]  req_vec;
    logic [NUM_UNITS-1:0]  pick_vec;
    logic [NUM_UNITS-1:0]  grant_vec;
    logic                  grant_any;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;

    logic                  writereg_q, writereg_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  sb_clear_q, sb_clear_d;

    always_comb begin
        req_vec           = '0;
        req_vec[UNIT_ALU] = alu_wb_req;
        req_vec[UNIT_SHF] = shf_wb_req;
        req_vec[UNIT_MEM] = mem_wb_req;
    end

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [1:0] last_grant_q, last_grant_d;

    rr_pick3 u_rr_pick3 (
        .req   (req_vec),
        .ptr   (last_grant_q),
        .grant (pick_vec)
    );

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_any) last_grant_d = onehot_to_idx(grant_vec);
    end

    always_ff @(posedge clock) begin
        if (reset) last_grant_q <= UNIT_MEM;
        else       last_grant_q <= last_grant_d;
    end
`else
    always_comb begin
        pick_vec = '0;
        if      (req_vec[UNIT_MEM]) pick_vec[UNIT_MEM] = 1'b1;
        else if (req_vec[UNIT_ALU]) pick_vec[UNIT_ALU] = 1'b1;
        else if (req_vec[UNIT_SHF]) pick_vec[UNIT_SHF] = 1'b1;
    end
`endif

    // Stall or reset blocks acceptance outright, so no requester is retired.
    assign grant_vec = (reset || wb_stall) ? '0 : pick_vec;
    assign grant_any = |grant_vec;

    assign alu_wb_grant = grant_vec[UNIT_ALU];
    assign shf_wb_grant = grant_vec[UNIT_SHF];
    assign mem_wb_grant = grant_vec[UNIT_MEM];

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        if (grant_vec[UNIT_ALU]) begin
            sel_addr = alu_wb_addr;
            sel_data = alu_wb_data;
        end else if (grant_vec[UNIT_SHF]) begin
            sel_addr = shf_wb_addr;
            sel_data = shf_wb_data;
        end else if (grant_vec[UNIT_MEM]) begin
            sel_addr = mem_wb_addr;
            sel_data = mem_wb_data;
        end
    end

    // Writes to register 0 are dropped but still retire the scoreboard entry.
    always_comb begin
        writereg_d = grant_any && (sel_addr != '0);
        sb_clear_d = grant_any;
        addr_d     = grant_any ? sel_addr : addr_q;
        data_d     = grant_any ? sel_data : data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            writereg_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            sb_clear_q <= 1'b0;
        end else begin
            writereg_q <= writereg_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sb_clear_q <= sb_clear_d;
        end
    end

    assign wb_reg_writereg = writereg_q;
    assign wb_reg_addr     = addr_q;
    assign wb_reg_data     = data_q;
    assign wb_sb_clear     = sb_clear_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed plus random bench for wb_arbiter against a behavioural
//            writeback model; honours WB_ARB_ROUND_ROBIN_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wb_stall = 1'b0;
    logic        alu_req = 1'b0, shf_req = 1'b0, mem_req = 1'b0;
    logic [4:0]  alu_addr = '0, shf_addr = '0, mem_addr = '0;
    logic [31:0] alu_data = '0, shf_data = '0, mem_data = '0;
    logic        alu_gnt, shf_gnt, mem_gnt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        sb_clr;

    int checks = 0;
    int errors = 0;

    // Reference state: last granted unit index and expected registered outputs.
    int          m_last = 2;
    logic        m_we = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic        m_clr = 1'b0;
    int          last_gnt;

    always #5 clock = ~clock;

    wb_arbiter dut (
        .clock           (clock),
        .reset           (reset),
        .wb_stall        (wb_stall),
        .alu_wb_req      (alu_req),
        .shf_wb_req      (shf_req),
        .mem_wb_req      (mem_req),
        .alu_wb_addr     (alu_addr),
        .shf_wb_addr     (shf_addr),
        .mem_wb_addr     (mem_addr),
        .alu_wb_data     (alu_data),
        .shf_wb_data     (shf_data),
        .mem_wb_data     (mem_data),
        .alu_wb_grant    (alu_gnt),
        .shf_wb_grant    (shf_gnt),
        .mem_wb_grant    (mem_gnt),
        .wb_reg_writereg (we),
        .wb_reg_addr     (waddr),
        .wb_reg_data     (wdata),
        .wb_sb_clear     (sb_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Unit index the arbitration rules select, or -1 when nobody is eligible.
    function automatic int model_pick(input logic [2:0] req, input int last);
`ifdef WB_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++) begin
            if (req[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
`else
        if (req[2]) return 2;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
`endif
    endfunction

    task automatic cycle(input string tag);
        int          g;
        logic [2:0]  req_v;
        logic [2:0]  gexp;
        logic [4:0]  a;
        logic [31:0] d;
        #1;
        req_v = {mem_req, shf_req, alu_req};
        g     = (reset || wb_stall) ? -1 : model_pick(req_v, m_last);
        gexp  = (g < 0) ? 3'b000 : (3'b001 << g);
        chk({tag, "_grant"}, {29'd0, mem_gnt, shf_gnt, alu_gnt}, {29'd0, gexp});
        last_gnt = g;
        a = (g == 0) ? alu_addr : (g == 1) ? shf_addr : mem_addr;
        d = (g == 0) ? alu_data : (g == 1) ? shf_data : mem_data;
        @(posedge clock);
        if (reset) begin
            m_we = 1'b0; m_addr = '0; m_data = '0; m_clr = 1'b0; m_last = 2;
        end else if (g >= 0) begin
            m_we = (a != 5'd0); m_addr = a; m_data = d; m_clr = 1'b1; m_last = g;
        end else begin
            m_we = 1'b0; m_clr = 1'b0;
        end
        #1;
        chk({tag, "_we"},    {31'd0, we},     {31'd0, m_we});
        chk({tag, "_addr"},  {27'd0, waddr},  {27'd0, m_addr});
        chk({tag, "_data"},  wdata,           m_data);
        chk({tag, "_clr"},   {31'd0, sb_clr}, {31'd0, m_clr});
    endtask

    task automatic idle_inputs();
        alu_req = 1'b0; shf_req = 1'b0; mem_req = 1'b0; wb_stall = 1'b0; reset = 1'b0;
    endtask

    initial begin
        int exp_order[6];
`ifdef WB_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 0, 1, 2};
`else
        exp_order = '{2, 2, 2, 2, 2, 2};
`endif
        // Reset state.
        reset = 1'b1;
        cycle("reset0");
        cycle("reset1");
        chk("reset_we", {31'd0, we}, 32'd0);
        chk("reset_addr", {27'd0, waddr}, 32'd0);
        idle_inputs();

        // Lone ALU request.
        alu_req = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        cycle("alu_single");
        chk("alu_single_gidx", last_gnt, 0);
        chk("alu_single_addr5", {27'd0, waddr}, 32'd5);
        chk("alu_single_dbeef", wdata, 32'hDEADBEEF);
        idle_inputs();
        cycle("idle_after");

        // All three held continuously straight out of reset.
        reset = 1'b1;
        cycle("rst_b");
        idle_inputs();
        alu_req = 1'b1; shf_req = 1'b1; mem_req = 1'b1;
        alu_addr = 5'd1; shf_addr = 5'd2; mem_addr = 5'd3;
        alu_data = 32'h11; shf_data = 32'h22; mem_data = 32'h33;
        for (int i = 0; i < 6; i++) begin
            cycle("all3");
            chk("all3_order", last_gnt, exp_order[i]);
        end
        idle_inputs();

        // MEM write to register zero.
        mem_req = 1'b1; mem_addr = 5'd0; mem_data = 32'hCAFEF00D;
        cycle("mem_zero");
        chk("mem_zero_gidx", last_gnt, 2);
        chk("mem_zero_we", {31'd0, we}, 32'd0);
        chk("mem_zero_clr", {31'd0, sb_clr}, 32'd1);
        idle_inputs();

        // Stall with ALU+SHF pending, then release.
        alu_req = 1'b1; shf_req = 1'b1; wb_stall = 1'b1;
        alu_addr = 5'd7; shf_addr = 5'd9; alu_data = 32'hA1; shf_data = 32'hB2;
        for (int i = 0; i < 3; i++) cycle("stall");
        wb_stall = 1'b0;
        cycle("unstall");
        idle_inputs();

        // Grant followed immediately by reset.
        shf_req = 1'b1; shf_addr = 5'd12; shf_data = 32'h12345678;
        cycle("pre_rst");
        idle_inputs();
        reset = 1'b1;
        cycle("rst_after_gnt");
        chk("rst_after_gnt_we", {31'd0, we}, 32'd0);
        chk("rst_after_gnt_data", wdata, 32'd0);
        idle_inputs();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            alu_req  = 1'($urandom_range(0, 1));
            shf_req  = 1'($urandom_range(0, 1));
            mem_req  = 1'($urandom_range(0, 1));
            wb_stall = ($urandom_range(0, 3) == 0);
            reset    = ($urandom_range(0, 31) == 0);
            alu_addr = 5'($urandom_range(0, 31));
            shf_addr = 5'($urandom_range(0, 31));
            mem_addr = 5'($urandom_range(0, 31));
            alu_data = $urandom; shf_data = $urandom; mem_data = $urandom;
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
